// File: rtl/systolic_array_pkg.sv
// Shared sizing, vector types and fill latency for the systolic matrix-multiply array.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package systolic_array_pkg;

    localparam int DEF_BITS_AB = 8;
    localparam int DEF_BITS_C  = 16;
    localparam int DEF_DIM     = 8;

    // en cycles from the first skewed operand until every accumulator holds its final value
    localparam int FILL_CYCLES = 3 * DEF_DIM - 2;

    typedef logic signed [DEF_BITS_AB-1:0] ab_t;
    typedef ab_t [DEF_DIM-1:0]             ab_vec_t;
    typedef logic signed [DEF_BITS_C-1:0]  c_t;
    typedef c_t [DEF_DIM-1:0]              c_row_t;

endpackage

// File: rtl/systolic_array_tpumac.sv
// Single signed MAC cell: forwards a right and b down, accumulates a*b into acc.
// Latency: one en cycle per operand hop; acc updates on the same edge as the operands.
// Backpressure: none; en=0 freezes all state, WrEn loads acc regardless of en.
// Ports: clk/rst_n; en advance; WrEn load acc from cin; a_in/b_in operands in;
//        a_q/b_q registered operands out to neighbours; acc accumulator out.
module tpumac #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               WrEn,
    input  logic [BITS_AB-1:0] a_in,
    input  logic [BITS_AB-1:0] b_in,
    input  logic [BITS_C-1:0]  cin,
    output logic [BITS_AB-1:0] a_q,
    output logic [BITS_AB-1:0] b_q,
    output logic [BITS_C-1:0]  acc
);

    localparam int PW = 2 * BITS_AB;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;

    // Full-width signed product; the low PW bits of the extended multiply are exact.
    assign a_ext = PW'($signed(a_in));
    assign b_ext = PW'($signed(b_in));
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
        end else begin
            if (en) begin
                a_q <= a_in;
                b_q <= b_in;
            end
            // A row load wins over accumulation; the sum wraps modulo 2^BITS_C.
            if (WrEn) begin
                acc <= cin;
            end else if (en) begin
                acc <= acc + BITS_C'(prod);
            end
        end
    end

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary systolic array computing C = A*B from skewed A columns / B rows.
// Latency: FILL_CYCLES en cycles for a full product; Cout is combinational from Crow.
// Backpressure: none; en=0 stalls the whole grid in place without bubbles.
// Ports: clk/rst_n; en advance; WrEn load row Crow from Cin; A[r] into column 0;
//        B[c] into row 0; Crow row select for load and readback; Cout selected row.
module systolic_array
    import systolic_array_pkg::*;
#(
    parameter int BITS_AB = DEF_BITS_AB,
    parameter int BITS_C  = DEF_BITS_C,
    parameter int DIM     = DEF_DIM
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            WrEn,
    input  logic [DIM-1:0][BITS_AB-1:0]     A,
    input  logic [DIM-1:0][BITS_AB-1:0]     B,
    input  logic [DIM-1:0][BITS_C-1:0]      Cin,
    input  logic [$clog2(DIM)-1:0]          Crow,
    output logic [DIM-1:0][BITS_C-1:0]      Cout
);

    localparam int CW = $clog2(DIM);

    logic [BITS_AB-1:0] a_q [DIM][DIM];
    logic [BITS_AB-1:0] b_q [DIM][DIM];
    logic [BITS_C-1:0]  acc [DIM][DIM];

    for (genvar r = 0; r < DIM; r++) begin : g_row
        logic row_wr;
        assign row_wr = WrEn && (Crow == CW'(r));

        for (genvar c = 0; c < DIM; c++) begin : g_col
            logic [BITS_AB-1:0] a_in;
            logic [BITS_AB-1:0] b_in;

            // Edge cells take the upstream skewed streams; interior cells take neighbours.
            if (c == 0) begin : g_a_edge
                assign a_in = A[r];
            end else begin : g_a_int
                assign a_in = a_q[r][c-1];
            end

            if (r == 0) begin : g_b_edge
                assign b_in = B[c];
            end else begin : g_b_int
                assign b_in = b_q[r-1][c];
            end

            tpumac #(
                .BITS_AB (BITS_AB),
                .BITS_C  (BITS_C)
            ) u_mac (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (en),
                .WrEn (row_wr),
                .a_in (a_in),
                .b_in (b_in),
                .cin  (Cin[c]),
                .a_q  (a_q[r][c]),
                .b_q  (b_q[r][c]),
                .acc  (acc[r][c])
            );
        end
    end

    for (genvar c = 0; c < DIM; c++) begin : g_rd
        assign Cout[c] = acc[Crow][c];
    end

endmodule

// File: doc/systolic_array.md
# systolic_array

Compute stage directly downstream of the A-operand memory. A DIM×DIM grid of signed multiply-accumulate cells consumes the skewed (rhombus-shaped) A columns produced by the A memory and the matching skewed B rows, and accumulates C = A·B in place. Results are preloaded or read back one row at a time through a row-select port.

## Interface
- BITS_AB, 8: width of signed A/B operands
- BITS_C, 16: width of signed accumulators and C data
- DIM, 8: array dimension (rows = columns)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance array: shift operands and accumulate
- WrEn  in  1  load Cin into accumulator row Crow
- A  in  DIM×BITS_AB signed  A[r] enters cell (r,0), already skewed by upstream
- B  in  DIM×BITS_AB signed  B[c] enters cell (0,c), already skewed by upstream
- Cin  in  DIM×BITS_C signed  row data for WrEn load
- Crow  in  $clog2(DIM)  row select for load and readback
- Cout  out  DIM×BITS_C signed  accumulator row Crow

## Operation
- Cell (r,c) holds three registers: a_q (passes right), b_q (passes down), acc.
- Cell operand inputs: a_in = A[r] for c=0, else a_q of (r,c-1); b_in = B[c] for r=0, else b_q of (r-1,c).
- en=1: a_q←a_in, b_q←b_in, acc←acc + a_in·b_in.
- en=0: all registers hold, including with WrEn=0.
- Arithmetic: full 2·BITS_AB signed product, sign-extended to BITS_C, sum taken modulo 2^BITS_C (wraps, no saturation).
- WrEn=1: every acc in row Crow ← Cin[c]. This overrides accumulation for that row only. Other rows accumulate if en=1.
- WrEn does not affect a_q/b_q; operand shifting follows en alone.
- Cout[c] = acc of cell (Crow,c), combinational from Crow. A load is visible on Cout the cycle after the WrEn edge.
- Upstream drives zeros outside the valid rhombus. The array does not gate operands.

## Timing
- Reset: all a_q, b_q, acc = 0 immediately on rst_n low. Cout = 0 for every Crow.
- Operand latency: one en cycle per hop. Data at A[r] reaches column c after c en cycles.
- Full product with skewed inputs (A[r] delayed r cycles, B[c] delayed c cycles):
  - first valid element on en cycle 0;
  - acc(r,c) final after en cycle r+c+DIM-1;
  - whole matrix final after 3·DIM-2 en cycles (22 for DIM=8).
- Stalls (en=0) insert no bubbles. The result is identical to an unstalled run.
- Reset mid-computation clears all state. Partial results are discarded, with no recovery.

## Structure
- Shared package holds:
  - default BITS_AB, BITS_C, DIM;
  - typedefs for the operand vector and the C row vector;
  - the localparam for the 3·DIM-2 fill latency, used by the controller and bench.
- One sub-module: tpumac (single cell: a_q/b_q/acc, en, WrEn-load of its Cin).
- The array is a generate grid of DIM×DIM tpumac instances plus the Crow readback mux.

## Test plan
- Reset: assert rst_n=0 mid-run, sweep Crow 0..7 → Cout all 0. Internal a_q/b_q are 0 the same cycle.
- Load/readback:
  - WrEn=1, Crow=3, Cin=1..8, en=0 → Crow=3 reads 1..8;
  - all other rows read 0.
- Identity product: A=I, B[i][j]=i·8+j, skewed, 22 en cycles → each row r reads r·8..r·8+7.
- Stall: same stimulus as the identity product with en=0 for 5 cycles after cycle 10 → final C bit-identical to the unstalled run.
- Wrap: cell (0,0) with A=-128, B=-128 accumulated 3 times from 0 → acc = 49152 mod 2^16 = -16384.
- Simultaneous WrEn/en:
  - WrEn on Crow=2 with Cin=0 during streaming → row 2 is 0 the next cycle, then resumes accumulating;
  - rows ≠2 are unaffected.
